// File: rtl/relay_sink_if.sv
// Data-width package and the upstream/reader bus bundle for relay_sink.
// The beats/stalls signals exist only when RELAY_SINK_STATS_EN is defined.
package relay_sink_pkg;
  localparam int unsigned NUM = 15;
endpackage

interface relay_sink_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic signed [relay_sink_pkg::NUM:0] in;
  logic                                _valid;
  logic                                delay_;
  logic                                rd;
  logic                                valid;
  logic signed [relay_sink_pkg::NUM:0] out;
  logic [CW-1:0]                       count;
`ifdef RELAY_SINK_STATS_EN
  logic [31:0]                         beats;
  logic [31:0]                         stalls;
`endif

  // Upstream relay and reader side
  modport master (
    output in, _valid, rd,
    input  delay_, valid, out, count
`ifdef RELAY_SINK_STATS_EN
    , input beats, stalls
`endif
  );

  // Sink side
  modport slave (
    input  in, _valid, rd,
    output delay_, valid, out, count
`ifdef RELAY_SINK_STATS_EN
    , output beats, stalls
`endif
  );
endinterface

// File: rtl/relay_sink.sv
// First-word-fall-through FIFO terminating a relay chain, with registered stall back to upstream.
// Optional RELAY_SINK_STATS_EN adds accepted-beat and stall-cycle counters.
module relay_sink #(
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  input logic         enable,
  relay_sink_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef logic signed [relay_sink_pkg::NUM:0] data_t;

  data_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_d;

  logic           w_valid;
  logic           w_push;
  logic           w_pop;
  logic [CW-1:0]  w_count_next;

  assign w_valid      = (r_count != '0);
  assign w_push       = enable & ~reset & bus._valid & ~r_d;
  assign w_pop        = enable & ~reset & bus.rd & w_valid;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // Pointers, occupancy and the stall flag; disabled cycles see no push/pop so state holds
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_d     <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_next;
      r_d     <= (w_count_next == CW'(DEPTH));
    end
  end

  // Storage needs no reset: only entries below count are ever exposed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.in;
  end

  // Reset masks the stale stall flag so upstream only sees NOT enable during reset
  assign bus.delay_ = (r_d & ~reset) | ~enable;
  assign bus.valid  = w_valid;
  assign bus.out    = w_valid ? r_mem[r_rptr] : '0;
  assign bus.count  = r_count;

`ifdef RELAY_SINK_STATS_EN
  logic [31:0] r_beats;
  logic [31:0] r_stalls;

  // Free-running wrap-around statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beats  <= '0;
      r_stalls <= '0;
    end else begin
      if (w_push) r_beats <= r_beats + 32'd1;
      if (enable & bus._valid & r_d) r_stalls <= r_stalls + 32'd1;
    end
  end

  assign bus.beats  = r_beats;
  assign bus.stalls = r_stalls;
`endif

endmodule

// File: tb/tb_relay_sink.sv
// Directed and relay-driven end-to-end checks for relay_sink (DEPTH=4).
// Stats checks are compiled in only when RELAY_SINK_STATS_EN is defined.
module tb_relay_sink;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NBEATS = 1000;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  int n_tests = 0;
  int n_fail  = 0;

  relay_sink_if #(.DEPTH(DEPTH)) bus ();

  relay_sink #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic signed [relay_sink_pkg::NUM:0] exp_q [NBEATS];

  initial begin
    int sent;
    int recv;
    int cyc;
    bit pending;
    bit acc;
    bit max_ok;

    reset      = 1'b1;
    enable     = 1'b1;
    bus.in     = '0;
    bus._valid = 1'b0;
    bus.rd     = 1'b0;

    // Reset state
    tick();
    check("rst_count", bus.count, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_delay", bus.delay_, 0);

    // Basic flow: 1,2,3
    reset = 1'b0; bus._valid = 1'b1; bus.in = 16'sd1;
    tick();
    check("lat_valid", bus.valid, 1);
    check("lat_out", bus.out, 1);
    bus.in = 16'sd2; tick();
    bus.in = 16'sd3; tick();
    check("flow_count", bus.count, 3);
    check("flow_out", bus.out, 1);
    check("flow_valid", bus.valid, 1);
    check("flow_delay", bus.delay_, 0);

    // Fill and stall: 4 fills the FIFO, 5 is held
    bus.in = 16'sd4; tick();
    check("full_count", bus.count, 4);
    check("full_delay", bus.delay_, 1);
    bus.in = 16'sd5; tick();
    check("stall_count", bus.count, 4);
`ifdef RELAY_SINK_STATS_EN
    check("stall_stats1", bus.stalls, 1);
`endif
    tick();
    check("stall_count2", bus.count, 4);
    check("stall_out", bus.out, 1);
`ifdef RELAY_SINK_STATS_EN
    check("stall_stats2", bus.stalls, 2);
`endif

    // Pop at full: d clears at this edge, 5 lands the next cycle
    bus.rd = 1'b1; tick();
    check("popfull_count", bus.count, 3);
    check("popfull_out", bus.out, 2);
    check("popfull_delay", bus.delay_, 0);
    bus.rd = 1'b0; tick();
    check("resume_count", bus.count, 4);
    check("resume_delay", bus.delay_, 1);
`ifdef RELAY_SINK_STATS_EN
    check("resume_beats", bus.beats, 5);
    check("resume_stalls", bus.stalls, 3);
`endif
    bus._valid = 1'b0; bus.in = '0; bus.rd = 1'b1;
    check("drain_a", bus.out, 2); tick();
    check("drain_b", bus.out, 3); tick();
    check("drain_c", bus.out, 4); tick();
    check("drain_d", bus.out, 5); tick();
    check("drain_empty_count", bus.count, 0);
    check("drain_empty_valid", bus.valid, 0);
    check("drain_empty_out", bus.out, 0);

    // Simultaneous push/pop at count=2
    bus.rd = 1'b0; bus._valid = 1'b1; bus.in = 16'sd8; tick();
    bus.in = 16'sd9; tick();
    check("sim_pre_count", bus.count, 2);
    bus.in = 16'sd7; bus.rd = 1'b1; tick();
    check("sim_count", bus.count, 2);
    check("sim_out", bus.out, 9);
    bus._valid = 1'b0; bus.in = '0;
    tick();
    check("sim_order", bus.out, 7);
    tick();
    check("sim_empty", bus.count, 0);
`ifdef RELAY_SINK_STATS_EN
    check("sim_beats", bus.beats, 8);
`endif

    // Read from empty is ignored
    tick();
    check("empty_rd_count", bus.count, 0);
    check("empty_rd_valid", bus.valid, 0);
    check("empty_rd_out", bus.out, 0);
    check("empty_rd_delay", bus.delay_, 0);

    // Disabled block freezes and backpressures
    bus.rd = 1'b0; bus._valid = 1'b1;
    bus.in = 16'sd10; tick();
    bus.in = 16'sd11; tick();
    bus.in = 16'sd12; tick();
    enable = 1'b0; bus.rd = 1'b1; bus.in = 16'sd13;
    #1;
    check("dis_delay", bus.delay_, 1);
    tick();
    check("dis_count", bus.count, 3);
    check("dis_out", bus.out, 10);

    // Mid-stream reset with count=3 and a beat in flight
    enable = 1'b1; bus.rd = 1'b0; bus.in = 16'sd14;
    reset = 1'b1;
    #1;
    check("rst_mid_delay_in", bus.delay_, 0);
    tick();
    check("rst_mid_count", bus.count, 0);
    check("rst_mid_valid", bus.valid, 0);
    check("rst_mid_out", bus.out, 0);
    check("rst_mid_delay", bus.delay_, 0);
`ifdef RELAY_SINK_STATS_EN
    check("rst_mid_beats", bus.beats, 0);
    check("rst_mid_stalls", bus.stalls, 0);
`endif
    reset = 1'b0; bus._valid = 1'b0; bus.in = '0;
    tick();
    check("post_rst_count", bus.count, 0);

    // End-to-end: behavioural relay holding its beat while stalled, random reader
    for (int i = 0; i < int'(NBEATS); i++) exp_q[i] = 16'($urandom);
    sent = 0; recv = 0; cyc = 0; pending = 1'b0; max_ok = 1'b1;
    while (recv < int'(NBEATS) && cyc < 40000) begin
      if (!pending && sent < int'(NBEATS) && $urandom_range(0, 3) != 0) begin
        pending    = 1'b1;
        bus.in     = exp_q[sent];
        bus._valid = 1'b1;
      end else if (!pending) begin
        bus.in     = '0;
        bus._valid = 1'b0;
      end
      bus.rd = 1'($urandom_range(0, 1));
      #1;
      if (bus.count > (DEPTH)) max_ok = 1'b0;
      acc = bus._valid && !bus.delay_;
      if (bus.rd && bus.valid) begin
        check("e2e_data", bus.out, exp_q[recv]);
        recv++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        pending = 1'b0;
        sent++;
      end
      cyc++;
    end
    check("e2e_recv", recv, NBEATS);
    check("e2e_max_count", max_ok, 1);
    bus._valid = 1'b0; bus.rd = 1'b0;
    tick();
    check("e2e_final_count", bus.count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
